// File: rtl/approx_cmp_pkg.sv
// Shared width, comparator resolution and FSM state encoding for the approximate max tracker.
package approx_cmp_pkg;

   localparam int DATA_W = 8;

   // Samples that differ only in the low CMP_LSB bits compare as equal.
   localparam int CMP_LSB = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

endpackage

// File: rtl/approx_comparator_8_bit.sv
// Approximate magnitude comparator: only the upper DATA_W-CMP_LSB bits take part,
// so values within the same 2^CMP_LSB bucket are reported equal. Flags are one-hot.
module approx_comparator_8_bit
   import approx_cmp_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              AeqB,
   output logic              AgtB,
   output logic              AltB
);

   logic [DATA_W-CMP_LSB-1:0] a_hi;
   logic [DATA_W-CMP_LSB-1:0] b_hi;

   assign a_hi = a[DATA_W-1:CMP_LSB];
   assign b_hi = b[DATA_W-1:CMP_LSB];

   assign AeqB = (a_hi == b_hi);
   assign AgtB = (a_hi >  b_hi);
   assign AltB = (a_hi <  b_hi);

endmodule

// File: rtl/approx_max_tracker.sv
// Per-frame maximum tracker built on one approximate comparator.
// Define APPROX_TIE_COUNT_EN to build the tie counter; otherwise tie_cnt is tied to 0.
//
// state  | meaning
// IDLE   | waiting for the first sample of a frame
// ACCUM  | comparing later samples against the running maximum
// OUTPUT | result presented, waiting for out_ready
module approx_max_tracker
   import approx_cmp_pkg::*;
#(
   parameter  int FRAME_LEN = 16,
   localparam int IDX_W     = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_max,
   output logic [IDX_W-1:0]  out_idx,
   output logic [IDX_W-1:0]  tie_cnt,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   max_q, max_d;
   logic                valid_q, valid_d;

   logic                accept;
   logic                cmp_eq;
   logic                cmp_gt;
   logic                cmp_lt;

   assign in_ready = (state_q != OUTPUT) && !rst;
   assign accept   = in_valid && in_ready;

   approx_comparator_8_bit u_cmp (
      .a    (in_data),
      .b    (max_q),
      .AeqB (cmp_eq),
      .AgtB (cmp_gt),
      .AltB (cmp_lt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      max_d   = max_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               max_d   = in_data;
               idx_d   = '0;
               cnt_d   = IDX_W'(1);
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               // Strictly greater only, so the earliest of equal samples keeps the index.
               if ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) begin
                  max_d = in_data;
                  idx_d = cnt_q;
               end
               cnt_d = cnt_q + IDX_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = OUTPUT;
                  valid_d = 1'b1;
               end
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         max_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         max_q   <= max_d;
         valid_q <= valid_d;
      end
   end

   assign out_max   = max_q;
   assign out_idx   = idx_q;
   assign out_valid = valid_q;

`ifdef APPROX_TIE_COUNT_EN
   logic [IDX_W-1:0] ties_q, ties_d;
   logic             frame_start;
   logic             frame_step;

   assign frame_start = accept && (state_q == IDLE);
   assign frame_step  = accept && (state_q == ACCUM);

   // At most FRAME_LEN-1 ties per frame, which always fits in IDX_W bits.
   always_comb begin
      ties_d = ties_q;
      if (frame_start) begin
         ties_d = '0;
      end else if (frame_step && cmp_eq) begin
         ties_d = ties_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ties_q <= '0;
      end else begin
         ties_q <= ties_d;
      end
   end

   assign tie_cnt = ties_q;
`else
   assign tie_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_max_tracker.sv
// Scoreboard bench for approx_max_tracker with FRAME_LEN = 4: directed frames plus random frames,
// random valid gaps and random/held out_ready.
module tb_approx_max_tracker;

   localparam int FL = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_max;
   logic [IW-1:0] out_idx;
   logic [IW-1:0] tie_cnt;
   logic          out_valid;
   logic          out_ready;

   approx_max_tracker #(.FRAME_LEN(FL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_max   (out_max),
      .out_idx   (out_idx),
      .tie_cnt   (tie_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mx;
      int idx;
      int ties;
      int edge_n;
   } exp_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         ready_mode = 0;   // 0: always ready, 1: random, 2: hold five valid cycles
   int         valid_seen = 0;
   bit         post_pop = 0;
   exp_t       sb[$];
   exp_t       held;
   logic [7:0] cur[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Reference: bucketed values (x/4) decide greater/equal; earliest maximum keeps its index.
   function automatic exp_t model(input logic [7:0] s[$]);
      exp_t e;
      int   m;
      e.mx   = s[0];
      e.idx  = 0;
      e.ties = 0;
      e.edge_n = 0;
      for (int i = 1; i < s.size(); i++) begin
         m = e.mx;
         if (int'(s[i]) / 4 > m / 4) begin
            e.mx  = s[i];
            e.idx = i;
         end else if (int'(s[i]) / 4 == m / 4) begin
            e.ties++;
         end
      end
`ifndef APPROX_TIE_COUNT_EN
      e.ties = 0;
`endif
      return e;
   endfunction

   task automatic send(input logic [7:0] d, input bit gap);
      bit   acc = 0;
      bit   tog = 0;
      int   budget = 0;
      exp_t e;
      while (!acc) begin
         in_valid = gap ? tog : 1'b1;
         in_data  = in_valid ? d : 8'($urandom);
         tog = ~tog;
         @(negedge clk);
         acc = in_valid && in_ready && !rst;
         if (acc) begin
            cur.push_back(d);
            if (cur.size() == FL) begin
               e = model(cur);
               e.edge_n = cyc + 1;
               sb.push_back(e);
               cur.delete();
            end
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         budget++;
         if (!acc && budget > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept_within_200");
            return;
         end
      end
   endtask

   task automatic frame(input logic [7:0] s[FL], input bit gap);
      for (int i = 0; i < FL; i++) send(s[i], gap);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom);
         default: out_ready = (valid_seen >= 5);
      endcase
   end

   // Monitor: compares the presented result with the scoreboard head and checks hold/bubble behaviour.
   always @(negedge clk) begin
      if (post_pop && !rst) begin
         check("bubble_out_valid", int'(out_valid), 0);
         check("bubble_in_ready", int'(in_ready), 1);
      end
      post_pop = 0;
      if (!rst && out_valid) begin
         if (valid_seen == 0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
               held = sb[0];
               check("out_max", int'(out_max), held.mx);
               check("out_idx", int'(out_idx), held.idx);
               check("tie_cnt", int'(tie_cnt), held.ties);
               check("latency_edge", cyc, held.edge_n);
            end
         end else begin
            check("hold_out_max", int'(out_max), held.mx);
            check("hold_out_idx", int'(out_idx), held.idx);
            check("hold_tie_cnt", int'(tie_cnt), held.ties);
         end
         check("in_ready_in_output", int'(in_ready), 0);
         valid_seen++;
         if (out_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            valid_seen = 0;
            post_pop = 1;
         end
      end
   end

   initial begin
      logic [7:0] prev;
      logic [7:0] r[FL];
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_max", int'(out_max), 0);
      check("rst_out_idx", int'(out_idx), 0);
      check("rst_tie_cnt", int'(tie_cnt), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", int'(in_ready), 1);

      frame('{8'h10, 8'h80, 8'h20, 8'h40}, 0);
      frame('{8'hAA, 8'hAA, 8'h0F, 8'hAA}, 0);
      drain();

      ready_mode = 2;
      frame('{8'h33, 8'h31, 8'h90, 8'h92}, 0);
      frame('{8'h05, 8'h06, 8'h07, 8'h04}, 0);
      drain();
      ready_mode = 0;

      send(8'h55, 0);
      send(8'hC0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cur.delete();
      @(negedge clk);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame('{8'h01, 8'h02, 8'h03, 8'hF0}, 0);
      drain();

      frame('{8'h10, 8'h80, 8'h20, 8'h40}, 1);
      frame('{8'hAA, 8'hAA, 8'h0F, 8'hAA}, 1);
      drain();

      ready_mode = 1;
      prev = 8'($urandom);
      for (int f = 0; f < 30; f++) begin
         for (int i = 0; i < FL; i++) begin
            r[i] = ($urandom_range(0, 2) == 0) ? (prev ^ 8'($urandom_range(0, 3))) : 8'($urandom);
            prev = r[i];
         end
         frame(r, 1'($urandom));
      end
      drain();
      ready_mode = 0;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
